// File: rtl/rf_scan_reader.sv
// Multi-channel RF power-detector scanner. It steps one shared ADC across the
// enabled channels, averages each channel and reports a saturated signed dBm code.
//
// state      | meaning
// S_IDLE     | ADC off, waiting for start
// S_SELECT   | mux switched, settle timer running
// S_START    | one-cycle conversion start pulse
// S_WAIT_EOC | waiting for end of conversion, timeout timer running
// S_CONVERT  | average -> dBm, publish the result
// S_NEXT     | advance to the next enabled channel or finish the scan
module rf_scan_reader #(
  parameter int NUM_CH   = 4,
  parameter int ADC_W    = 10,
  parameter int AVG_LOG2 = 2,
  parameter int OFFSET   = 512,
  parameter int SHIFT    = 2,
  parameter int SETTLE   = 4,
  parameter int TIMEOUT  = 255,
  localparam int CH_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_en,
  output logic [CH_W-1:0]   adc_mux_sel,
  output logic              adc_start,
  input  logic              adc_eoc,
  input  logic [ADC_W-1:0]  adc_data,
  output logic [7:0]        power_dbm,
  output logic [CH_W-1:0]   pwr_ch,
  output logic              pwr_valid,
  output logic              scan_done,
  output logic              busy,
  output logic [NUM_CH-1:0] err_flags
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [SET_W-1:0]      SETTLE_LD = SET_W'(SETTLE - 1);
  localparam logic [TMO_W-1:0]      TMO_LD    = TMO_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2:0]     LAST_SMP  = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
  localparam logic [ADC_W-1:0]      OFF_C     = ADC_W'(OFFSET);
  localparam logic signed [ADC_W:0] SAT_HI    = (ADC_W + 1)'(127);
  localparam logic signed [ADC_W:0] SAT_LO    = (ADC_W + 1)'(-128);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_START, S_WAIT_EOC, S_CONVERT, S_NEXT
  } state_t;

  state_t                  state;
  logic [NUM_CH-1:0]       mask_q;
  logic [SET_W-1:0]        settle_cnt;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [ACC_W-1:0]        acc;
  logic [AVG_LOG2:0]       smp_cnt;
  logic [ADC_W-1:0]        avg;
  logic signed [ADC_W:0]   diff;
  logic signed [ADC_W:0]   scaled;
  logic [7:0]              sat;
  logic [CH_W:0]           first_new;
  logic [CH_W:0]           next_ch;

  // {found, index} of the lowest set bit of m at or above position lo
  function automatic logic [CH_W:0] pick(input logic [NUM_CH-1:0] m, input int lo);
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
    return r;
  endfunction

  assign first_new = pick(ch_mask, 0);
  assign next_ch   = pick(mask_q, int'(adc_mux_sel) + 1);

  assign avg    = ADC_W'(acc >> AVG_LOG2);
  assign diff   = $signed({1'b0, avg}) - $signed({1'b0, OFF_C});
  assign scaled = diff >>> SHIFT;

  always_comb begin
    sat = scaled[7:0];
    if (scaled > SAT_HI)      sat = 8'h7f;
    else if (scaled < SAT_LO) sat = 8'h80;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      settle_cnt  <= '0;
      tmo_cnt     <= '0;
      acc         <= '0;
      smp_cnt     <= '0;
      adc_en      <= 1'b0;
      adc_mux_sel <= '0;
      adc_start   <= 1'b0;
      power_dbm   <= '0;
      pwr_ch      <= '0;
      pwr_valid   <= 1'b0;
      scan_done   <= 1'b0;
      busy        <= 1'b0;
      err_flags   <= '0;
    end else begin
      adc_start <= 1'b0;
      pwr_valid <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_q     <= ch_mask;
            err_flags  <= '0;
            busy       <= 1'b1;
            adc_en     <= 1'b1;
            settle_cnt <= SETTLE_LD;
            if (first_new[CH_W]) begin
              adc_mux_sel <= first_new[CH_W-1:0];
              state       <= S_SELECT;
            end else begin
              state <= S_NEXT;
            end
          end
        end
        S_SELECT: begin
          acc     <= '0;
          smp_cnt <= '0;
          if (settle_cnt == '0) begin
            adc_start <= 1'b1;
            state     <= S_START;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        S_START: begin
          tmo_cnt <= TMO_LD;
          state   <= S_WAIT_EOC;
        end
        S_WAIT_EOC: begin
          // a conversion landing on the expiry cycle still counts
          if (adc_eoc) begin
            acc     <= acc + ACC_W'(adc_data);
            smp_cnt <= smp_cnt + (AVG_LOG2 + 1)'(1);
            if (smp_cnt == LAST_SMP) begin
              state <= S_CONVERT;
            end else begin
              adc_start <= 1'b1;
              state     <= S_START;
            end
          end else if (tmo_cnt == '0) begin
            err_flags[adc_mux_sel] <= 1'b1;
            state                  <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        S_CONVERT: begin
          power_dbm <= sat;
          pwr_ch    <= adc_mux_sel;
          pwr_valid <= 1'b1;
          state     <= S_NEXT;
        end
        S_NEXT: begin
          if (next_ch[CH_W]) begin
            adc_mux_sel <= next_ch[CH_W-1:0];
            settle_cnt  <= SETTLE_LD;
            state       <= S_SELECT;
          end else begin
            scan_done <= 1'b1;
            if (continuous) begin
              mask_q     <= ch_mask;
              err_flags  <= '0;
              settle_cnt <= SETTLE_LD;
              if (first_new[CH_W]) begin
                adc_mux_sel <= first_new[CH_W-1:0];
                state       <= S_SELECT;
              end else begin
                state <= S_NEXT;
              end
            end else begin
              busy   <= 1'b0;
              adc_en <= 1'b0;
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_scan_reader.sv
// Bench for rf_scan_reader: an ADC responder feeds random conversions and a
// queue of expected results built from the averaging/dBm rules.
module tb_rf_scan_reader;
  localparam int NUM_CH   = 4;
  localparam int CH_W     = 2;
  localparam int ADC_W    = 10;
  localparam int AVG_LOG2 = 2;
  localparam int OFFSET   = 512;
  localparam int SHIFT    = 2;
  localparam int SETTLE   = 4;
  localparam int TIMEOUT  = 255;
  localparam int N        = 1 << AVG_LOG2;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_EXPIRY = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic continuous = 1'b0;
  logic [NUM_CH-1:0] ch_mask = '0;
  logic adc_eoc;
  logic [ADC_W-1:0] adc_data;

  logic adc_en, adc_start, pwr_valid, scan_done, busy;
  logic [CH_W-1:0] adc_mux_sel, pwr_ch;
  logic [7:0] power_dbm;
  logic [NUM_CH-1:0] err_flags;

  logic adc_en_s1, adc_start_s1, pwr_valid_s1, scan_done_s1, busy_s1;
  logic [CH_W-1:0] adc_mux_sel_s1, pwr_ch_s1;
  logic [7:0] power_dbm_s1;
  logic [NUM_CH-1:0] err_flags_s1;

  typedef struct {int ch; int v; int v1;} exp_t;
  exp_t exp_q[$];
  int log_ch[$];
  int log_dbm[$];
  int ch_mode [NUM_CH];
  int const_data [NUM_CH];
  int sum [NUM_CH];
  int cnt [NUM_CH];
  int data_kind = 0;
  int fixed_dly = 0;
  int n_chk = 0, n_fail = 0;
  int n_pwr = 0, n_done = 0, n_start = 0;

  rf_scan_reader #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .OFFSET(OFFSET),
                   .SHIFT(SHIFT), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .adc_en(adc_en), .adc_mux_sel(adc_mux_sel), .adc_start(adc_start), .adc_eoc(adc_eoc),
    .adc_data(adc_data), .power_dbm(power_dbm), .pwr_ch(pwr_ch), .pwr_valid(pwr_valid),
    .scan_done(scan_done), .busy(busy), .err_flags(err_flags));

  // same stimulus with a finer scale so that saturation is reachable
  rf_scan_reader #(.NUM_CH(NUM_CH), .ADC_W(ADC_W), .AVG_LOG2(AVG_LOG2), .OFFSET(OFFSET),
                   .SHIFT(1), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .adc_en(adc_en_s1), .adc_mux_sel(adc_mux_sel_s1), .adc_start(adc_start_s1), .adc_eoc(adc_eoc),
    .adc_data(adc_data), .power_dbm(power_dbm_s1), .pwr_ch(pwr_ch_s1), .pwr_valid(pwr_valid_s1),
    .scan_done(scan_done_s1), .busy(busy_s1), .err_flags(err_flags_s1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int ref_dbm(input int total, input int sh);
    int s;
    s = ((total / N) - OFFSET) >>> sh;
    if (s > 127) s = 127;
    else if (s < -128) s = -128;
    return s;
  endfunction

  // ADC model: answers each conversion start on the selected channel
  initial begin
    int ch, d, dat;
    exp_t e;
    adc_eoc = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge clk); #1;
      adc_eoc = 1'b0;
      if (!rst_n) begin
        for (int i = 0; i < NUM_CH; i++) begin sum[i] = 0; cnt[i] = 0; end
      end else if (adc_start === 1'b1 && ch_mode[adc_mux_sel] != M_NEVER) begin
        ch = int'(adc_mux_sel);
        if (ch_mode[ch] == M_EXPIRY) d = TIMEOUT;
        else if (fixed_dly != 0) d = fixed_dly;
        else d = int'($urandom_range(1, 6));
        case (data_kind)
          0: dat = int'($urandom_range(0, (1 << ADC_W) - 1));
          1: dat = const_data[ch];
          default: dat = 600 + 4 * cnt[ch];
        endcase
        repeat (d) @(posedge clk);
        #1;
        adc_eoc = 1'b1;
        adc_data = ADC_W'(dat);
        sum[ch] += dat;
        cnt[ch]++;
        if (cnt[ch] == N) begin
          e.ch = ch;
          e.v = ref_dbm(sum[ch], SHIFT);
          e.v1 = ref_dbm(sum[ch], 1);
          exp_q.push_back(e);
          sum[ch] = 0;
          cnt[ch] = 0;
        end
      end
    end
  end

  // result monitor, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (adc_start === 1'b1) n_start++;
      if (scan_done === 1'b1) n_done++;
      if (pwr_valid === 1'b1) begin
        n_pwr++;
        log_ch.push_back(int'(pwr_ch));
        log_dbm.push_back(int'($signed(power_dbm)));
        chk("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pwr_ch", pwr_ch, e.ch);
          chk("power_dbm", $signed(power_dbm), e.v);
          chk("s1_valid", pwr_valid_s1, 1);
          chk("s1_ch", pwr_ch_s1, e.ch);
          chk("s1_dbm", $signed(power_dbm_s1), e.v1);
        end
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin @(posedge clk); #1; k++; end
    chk(tag, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_adc_start(input int budget, input string tag);
    int k = 0;
    while (adc_start !== 1'b1 && k < budget) begin @(posedge clk); #1; k++; end
    chk(tag, adc_start, 1);
  endtask

  task automatic wait_done_pulse(input int budget, input string tag);
    int k = 0;
    do begin @(posedge clk); #1; k++; end while (scan_done !== 1'b1 && k < budget);
    chk(tag, scan_done, 1);
  endtask

  task automatic kick();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_pwr, b_done, b_start, lc;
    for (int i = 0; i < NUM_CH; i++) begin ch_mode[i] = M_NORMAL; const_data[i] = 0; end

    repeat (3) @(posedge clk); #1;
    chk("rst_ctrl", {adc_en, adc_start, pwr_valid, scan_done, busy}, 0);
    chk("rst_sel", {adc_mux_sel, pwr_ch}, 0);
    chk("rst_dbm", power_dbm, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_s1", {adc_en_s1, adc_start_s1, pwr_valid_s1, scan_done_s1, busy_s1,
                   adc_mux_sel_s1, pwr_ch_s1, power_dbm_s1, err_flags_s1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ramp data 600..612 on channel 0, average 606 -> 23 dBm
    ch_mask = 4'b0001; data_kind = 2; fixed_dly = 3;
    b_pwr = n_pwr; b_done = n_done;
    kick();
    chk("t1_busy", busy, 1);
    chk("t1_adc_en", adc_en, 1);
    repeat (SETTLE - 1) @(posedge clk); #1;
    chk("t1_start_early", adc_start, 0);
    @(posedge clk); #1;
    chk("t1_start_pulse", adc_start, 1);
    wait_idle(400, "t1_idle");
    chk("t1_npwr", n_pwr - b_pwr, 1);
    if (log_dbm.size() > 0) chk("t1_dbm", log_dbm[log_dbm.size() - 1], 23);
    chk("t1_done", n_done - b_done, 1);
    fixed_dly = 0;

    // full-scale and zero data on channels 1 and 3
    ch_mask = 4'b1010; data_kind = 1; const_data[1] = 1023; const_data[3] = 0;
    b_pwr = n_pwr; lc = log_ch.size();
    kick();
    wait_idle(600, "t2_idle");
    chk("t2_npwr", n_pwr - b_pwr, 2);
    if (log_ch.size() >= lc + 2) begin
      chk("t2_first_ch", log_ch[lc], 1);
      chk("t2_second_ch", log_ch[lc + 1], 3);
      chk("t2_first_dbm", log_dbm[lc], 127);
      chk("t2_second_dbm", log_dbm[lc + 1], -128);
    end
    data_kind = 0;

    // channel 1 never answers: flag after the timeout, channel 2 still converts
    ch_mask = 4'b0110; ch_mode[1] = M_NEVER;
    b_pwr = n_pwr; b_done = n_done; lc = log_ch.size();
    kick();
    wait_adc_start(50, "t3_start");
    chk("t3_sel", adc_mux_sel, 1);
    repeat (TIMEOUT) @(posedge clk); #1;
    chk("t3_err_before", err_flags, 0);
    @(posedge clk); #1;
    chk("t3_err_set", err_flags, 4'b0010);
    wait_idle(600, "t3_idle");
    chk("t3_err_sticky", err_flags, 4'b0010);
    chk("t3_npwr", n_pwr - b_pwr, 1);
    if (log_ch.size() > lc) chk("t3_ch", log_ch[lc], 2);
    chk("t3_done", n_done - b_done, 1);

    // every answer lands on the last allowed cycle
    ch_mask = 4'b0010; ch_mode[1] = M_EXPIRY;
    b_pwr = n_pwr;
    kick();
    chk("t3b_err_cleared", err_flags, 0);
    wait_idle(2000, "t3b_idle");
    chk("t3b_err", err_flags, 0);
    chk("t3b_npwr", n_pwr - b_pwr, 1);
    ch_mode[1] = M_NORMAL;

    // empty mask: scan_done two cycles after the start edge
    ch_mask = 4'b0000;
    b_pwr = n_pwr; b_start = n_start;
    kick();
    chk("t4_done_early", scan_done, 0);
    chk("t4_busy", busy, 1);
    @(posedge clk); #1;
    chk("t4_done_pulse", scan_done, 1);
    chk("t4_busy_fall", busy, 0);
    @(posedge clk); #1;
    chk("t4_done_single", scan_done, 0);
    chk("t4_no_start", n_start - b_start, 0);
    chk("t4_no_pwr", n_pwr - b_pwr, 0);

    // free-running with mask changes taking effect only at the next scan
    ch_mask = 4'b0011; continuous = 1'b1;
    b_done = n_done; lc = log_ch.size();
    kick();
    ch_mask = 4'b0100;
    wait_done_pulse(400, "t5_scan1");
    wait_done_pulse(400, "t5_scan2");
    ch_mask = 4'b1001; continuous = 1'b0;
    wait_idle(400, "t5_idle");
    chk("t5_done", n_done - b_done, 3);
    chk("t5_nres", log_ch.size() - lc, 4);
    if (log_ch.size() >= lc + 4) begin
      chk("t5_seq0", log_ch[lc], 0);
      chk("t5_seq1", log_ch[lc + 1], 1);
      chk("t5_seq2", log_ch[lc + 2], 2);
      chk("t5_seq3", log_ch[lc + 3], 2);
    end

    // reset while waiting for a conversion
    ch_mask = 4'b0001; ch_mode[0] = M_NEVER;
    b_pwr = n_pwr; b_done = n_done;
    kick();
    wait_adc_start(50, "t6_start");
    repeat (5) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t6_ctrl", {adc_en, adc_start, pwr_valid, scan_done, busy}, 0);
    chk("t6_sel", {adc_mux_sel, pwr_ch}, 0);
    chk("t6_dbm", power_dbm, 0);
    chk("t6_err", err_flags, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ch_mode[0] = M_NORMAL;
    @(posedge clk); #1;
    chk("t6_no_pwr", n_pwr - b_pwr, 0);
    chk("t6_no_done", n_done - b_done, 0);
    ch_mask = 4'b0101;
    b_pwr = n_pwr;
    kick();
    wait_idle(600, "t6_idle");
    chk("t6_npwr", n_pwr - b_pwr, 2);

    // random masks and data
    for (int it = 0; it < 6; it++) begin
      ch_mask = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      b_pwr = n_pwr; b_done = n_done;
      kick();
      wait_idle(800, "rnd_idle");
      chk("rnd_err", err_flags, 0);
      chk("rnd_npwr", n_pwr - b_pwr, $countones(ch_mask));
      chk("rnd_done", n_done - b_done, 1);
    end

    chk("exp_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_scan_reader.md
# rf_scan_reader

Multi-channel successor to the single-shot RF detector reader. It scans a parametrised set of power-detector channels through one shared ADC, oversamples and averages each channel, converts each average to a saturated signed dBm code, and can free-run. It sits between the ADC front-end and the power-monitoring/telemetry logic, and adds a per-conversion timeout with error reporting.

## Interface
Parameters:
- NUM_CH, 4: number of detector channels; must be ≥ 2. CH_W = $clog2(NUM_CH).
- ADC_W, 10: ADC result width.
- AVG_LOG2, 2: each channel is averaged over 2^AVG_LOG2 conversions; 0 means a single sample.
- OFFSET, 512: ADC code for 0 dBm, unsigned, < 2^ADC_W.
- SHIFT, 2: right-shift that scales the difference to dBm; arithmetic shift.
- SETTLE, 4: mux settle cycles after a channel switch; must be ≥ 1.
- TIMEOUT, 255: maximum wait for adc_eoc per conversion, in cycles; must be ≥ 1.

Ports:
- clk, in, 1: single clock; all logic on rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- start, in, 1: level sampled in IDLE; starts a scan.
- continuous, in, 1: at end of scan, restart instead of returning to IDLE.
- ch_mask, in, NUM_CH: enabled channels; latched at every scan start.
- adc_en, out, 1: ADC and clock enable.
- adc_mux_sel, out, CH_W: 0-based channel index.
- adc_start, out, 1: one-cycle conversion-start pulse.
- adc_eoc, in, 1: end of conversion; adc_data is valid while it is high.
- adc_data, in, ADC_W: conversion result.
- power_dbm, out, 8: signed result, two's complement.
- pwr_ch, out, CH_W: channel of power_dbm.
- pwr_valid, out, 1: one-cycle pulse when power_dbm/pwr_ch update.
- scan_done, out, 1: one-cycle pulse at the end of each scan.
- busy, out, 1: high in any state other than IDLE.
- err_flags, out, NUM_CH: sticky timeout flag per channel; cleared at every scan start.

## Operation
- Reset value of every output and register is 0; the FSM resets to IDLE. Reset mid-scan aborts at the next edge with no pwr_valid and no scan_done.
- FSM states: IDLE, SELECT, START, WAIT_EOC, CONVERT, NEXT.
- IDLE → SELECT when start = 1.
  - On this edge: latch ch_mask, clear err_flags, and load the lowest set mask bit as the channel.
  - If the latched mask is 0, go to NEXT instead; this produces a scan_done pulse with no conversion.
- SELECT: adc_en = 1, adc_mux_sel = channel. Hold for SETTLE cycles, then go to START. Clear the accumulator and the sample counter.
- START: adc_start = 1 for exactly one cycle, then go to WAIT_EOC. Load the timeout counter.
- WAIT_EOC:
  - If adc_eoc = 1: add adc_data to the accumulator (ADC_W+AVG_LOG2 bits, unsigned, no overflow possible) and increment the sample counter.
    - If samples < 2^AVG_LOG2, go to START with no resettle.
    - Otherwise go to CONVERT.
  - Else, if the counter reaches TIMEOUT cycles: set err_flags[channel] and go to NEXT. The channel gets no pwr_valid and its partial accumulation is discarded.
  - If adc_eoc and expiry fall in the same cycle, adc_eoc wins.
  - adc_eoc is ignored in every other state.
- CONVERT: avg = acc >> AVG_LOG2 (truncate); d = avg − OFFSET, signed ADC_W+1 bits; s = d >>> SHIFT. Saturate s to [−128, 127] and register it into power_dbm, with pwr_ch = channel and pwr_valid = 1 for one cycle. Then go to NEXT.
- NEXT:
  - If a higher set bit exists in the latched mask, load it and go to SELECT.
  - Otherwise pulse scan_done. Then:
    - if continuous = 1, re-latch ch_mask, clear err_flags, and go to SELECT with the lowest set bit (NEXT again if the mask is 0);
    - else go to IDLE.
- adc_en is high in every state except IDLE. adc_mux_sel holds its value in IDLE.
- start while busy is ignored. Changes to ch_mask mid-scan have no effect until the next latch.

## Timing
- start sampled at edge E0: SELECT from E0; adc_en high in the cycle after E0. adc_start is high in cycle E0+SETTLE+1.
- Per conversion: START takes 1 cycle; WAIT_EOC takes at least 1 cycle. adc_eoc high in the first WAIT_EOC cycle gives the minimum of 2 cycles per sample.
- Per channel, minimum: SETTLE + 2·2^AVG_LOG2 + 2 cycles (CONVERT + NEXT).
- pwr_valid rises the cycle after CONVERT, together with the updated power_dbm/pwr_ch. power_dbm holds until the next pwr_valid.
- scan_done rises the cycle after NEXT of the last channel. busy falls in that same cycle when continuous = 0.
- Timeout: with adc_eoc low, err_flags[ch] sets TIMEOUT cycles after the adc_start cycle.

## Test plan
- Defaults, ch_mask = 4'b0001, adc_data 600, 604, 608, 612, eoc 3 cycles after each adc_start -> one pwr_valid with pwr_ch = 0 and power_dbm = 23 (avg 606); then scan_done; busy = 0.
- ch_mask = 4'b1010, constant data 1023, then 0 -> pwr_valid for ch 1 with 127, then ch 3 with −128, in order. Repeat with SHIFT = 1 and data 1023 -> 127 (saturated from 255).
- ch_mask = 4'b0110, adc_eoc never asserted for ch 1 -> err_flags = 4'b0010 after TIMEOUT; ch 2 converts normally; scan_done pulses once. Also drive eoc on the expiry cycle -> no error flag.
- ch_mask = 0 -> scan_done exactly 2 cycles after the start edge; no adc_start, no pwr_valid.
- continuous = 1, mask 4'b0011 -> repeating ch 0, ch 1 results with scan_done between scans. Changing ch_mask mid-scan takes effect only from the next scan. Dropping continuous -> IDLE after the current scan.
- rst_n low during WAIT_EOC -> next edge: all outputs 0, IDLE, no pwr_valid. start again -> normal scan.
